// File: rtl/bsg_counter_overflow_sched_pkg.sv
// Shared types for the overflow-counter time-slice scheduler.
package bsg_counter_overflow_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bsg_counter_overflow_set_en.sv
// Loadable, enable-gated up counter that flags when it reaches max_val_p and
// clears itself on the following edge.
module bsg_counter_overflow_set_en #(
    parameter int unsigned        width_p   = 24,
    parameter logic [width_p-1:0] max_val_p = '1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o,
    output logic               overflow_o
);

    logic [width_p-1:0] count_r;

    assign overflow_o = (count_r == max_val_p);
    assign count_o    = count_r;

    // Load beats the overflow clear, which beats the enable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (set_i) begin
            count_r <= val_i;
        end else if (overflow_o) begin
            count_r <= '0;
        end else if (en_i) begin
            count_r <= count_r + width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_counter_overflow_sched.sv
// Round-robin time-slice scheduler sharing one overflow counter among els_p
// requesters; each grant runs for exactly len ticks and ends in a tagged completion.
module bsg_counter_overflow_sched
    import bsg_counter_overflow_sched_pkg::*;
#(
    parameter int unsigned        width_p   = 24,
    parameter int unsigned        els_p     = 4,
    parameter logic [width_p-1:0] max_val_p = '1,
    localparam int unsigned       id_w_lp   = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         req_v_i,
    input  logic [els_p*width_p-1:0] req_len_i,
    output logic [els_p-1:0]         req_yumi_o,
    input  logic                     tick_i,
    output logic                     done_v_o,
    output logic [id_w_lp-1:0]       done_id_o,
    input  logic                     done_yumi_i,
    output logic                     busy_o,
    output logic [width_p-1:0]       count_o
);

    localparam logic [id_w_lp:0]  els_lp    = (id_w_lp+1)'(els_p);
    localparam logic [id_w_lp-1:0] last_id_lp = id_w_lp'(els_p - 1);
    localparam logic [els_p-1:0]  one_lp    = {{(els_p-1){1'b0}}, 1'b1};

    state_e state_r, state_n;

    logic [id_w_lp-1:0] rr_r;
    logic [id_w_lp-1:0] done_id_r;
    logic [id_w_lp-1:0] rr_n;
    logic [id_w_lp-1:0] gnt_id;
    logic [id_w_lp-1:0] rot_off;
    logic [id_w_lp:0]   gnt_sum;
    logic [2*els_p-1:0] req_dbl;
    logic [els_p-1:0]   req_rot;
    logic               grant;
    logic               ctr_en;
    logic               ctr_overflow;
    logic [width_p-1:0] ctr_val;
    logic [width_p-1:0] len_a [els_p];

    for (genvar i = 0; i < els_p; i++) begin : g_len
        assign len_a[i] = req_len_i[i*width_p +: width_p];
    end

    // Rotate so the rr pointer lands on bit 0, take the lowest set bit, then
    // add the pointer back modulo els_p to recover the requester id.
    always_comb begin
        req_dbl = {req_v_i, req_v_i};
        req_rot = els_p'(req_dbl >> rr_r);
        rot_off = '0;
        for (int unsigned k = els_p; k > 0; k--) begin
            if (req_rot[k-1]) begin
                rot_off = id_w_lp'(k - 1);
            end
        end
        gnt_sum = {1'b0, rr_r} + {1'b0, rot_off};
        if (gnt_sum >= els_lp) begin
            gnt_sum = gnt_sum - els_lp;
        end
        gnt_id = gnt_sum[id_w_lp-1:0];
        rr_n   = (gnt_id == last_id_lp) ? '0 : gnt_id + id_w_lp'(1);
    end

    always_comb begin
        state_n = state_r;
        grant   = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req_v_i) begin
                    grant   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (ctr_overflow) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (done_yumi_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            rr_r      <= '0;
            done_id_r <= '0;
        end else begin
            state_r <= state_n;
            if (grant) begin
                rr_r      <= rr_n;
                done_id_r <= gnt_id;
            end
        end
    end

    // Loading max - len makes the counter hit max after exactly len ticks.
    assign ctr_val = max_val_p - len_a[gnt_id];
    assign ctr_en  = (state_r == RUN) & tick_i;

    bsg_counter_overflow_set_en #(
        .width_p  (width_p),
        .max_val_p(max_val_p)
    ) u_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (grant),
        .val_i     (ctr_val),
        .en_i      (ctr_en),
        .count_o   (count_o),
        .overflow_o(ctr_overflow)
    );

    assign req_yumi_o = grant ? (one_lp << gnt_id) : '0;
    assign done_v_o   = (state_r == DONE);
    assign done_id_o  = done_id_r;
    assign busy_o     = (state_r != IDLE);

endmodule
